// File: rtl/jpeg_block_sched_pkg.sv
// Shared types and constants for the JPEG 8x8 block scheduler.
package jpeg_pkg;

  localparam int unsigned BLK_WORDS     = 16;
  localparam int unsigned BLK_ROW_BYTES = 8;

  typedef enum logic [2:0] {
    SCHED_IDLE    = 3'd0,
    SCHED_FETCH   = 3'd1,
    SCHED_KICK    = 3'd2,
    SCHED_WAIT_HI = 3'd3,
    SCHED_WAIT_LO = 3'd4,
    SCHED_READY   = 3'd5,
    SCHED_ADVANCE = 3'd6
  } sched_state_t;

  // Unsigned pixel to two's complement: flip the MSB of every byte lane.
  function automatic logic [31:0] level_shift(input logic [31:0] d);
    return d ^ 32'h8080_8080;
  endfunction

endpackage

// File: rtl/jpeg_block_sched_if.sv
// Bus-master read port and input block RAM write port of the block scheduler.
interface jpeg_block_sched_if #(
  parameter int unsigned AW = 32
);
  logic          m_req_o;
  logic [AW-1:0] m_adr_o;
  logic          m_ack_i;
  logic [31:0]   m_dat_i;
  logic [8:0]    bram_adr_o;
  logic [31:0]   bram_dat_o;
  logic          bram_we_o;

  modport master (
    output m_req_o, m_adr_o, bram_adr_o, bram_dat_o, bram_we_o,
    input  m_ack_i, m_dat_i
  );

  modport slave (
    input  m_req_o, m_adr_o, bram_adr_o, bram_dat_o, bram_we_o,
    output m_ack_i, m_dat_i
  );
endinterface

// File: rtl/jpeg_block_sched_addr_gen.sv
// Block/word counters and raster address generator; row offsets are accumulated, not multiplied.
module jpeg_blk_addr_gen
  import jpeg_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned BW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          init_i,
  input  logic          step_i,
  input  logic          adv_i,
  input  logic [AW-1:0] cfg_base_i,
  input  logic [BW-1:0] cfg_wblk_i,
  input  logic [BW-1:0] cfg_hblk_i,
  output logic [AW-1:0] m_adr_o,
  output logic [3:0]    widx_o,
  output logic [BW-1:0] blk_x_o,
  output logic [BW-1:0] blk_y_o,
  output logic          last_word_c,
  output logic          last_block_c
);

  logic [AW-1:0] base_q, base_d, row_off_q, row_off_d, blk_row_q, blk_row_d;
  logic [AW-1:0] col_off_q, col_off_d, m_adr_q, m_adr_d, stride_c;
  logic [BW-1:0] wblk_q, wblk_d, hblk_q, hblk_d, blk_x_q, blk_x_d, blk_y_q, blk_y_d;
  logic [3:0]    widx_q, widx_d;
  logic          last_x_c, last_y_c;

  assign stride_c     = AW'(wblk_q) * AW'(BLK_ROW_BYTES);
  assign last_x_c     = (blk_x_q == wblk_q - BW'(1));
  assign last_y_c     = (blk_y_q == hblk_q - BW'(1));
  assign last_word_c  = (widx_q == 4'(BLK_WORDS - 1));
  assign last_block_c = last_x_c && last_y_c;

  always_comb begin
    base_d    = base_q;
    wblk_d    = wblk_q;
    hblk_d    = hblk_q;
    blk_x_d   = blk_x_q;
    blk_y_d   = blk_y_q;
    widx_d    = widx_q;
    row_off_d = row_off_q;
    blk_row_d = blk_row_q;
    col_off_d = col_off_q;
    if (init_i) begin
      base_d    = cfg_base_i;
      wblk_d    = cfg_wblk_i;
      hblk_d    = cfg_hblk_i;
      blk_x_d   = '0;
      blk_y_d   = '0;
      widx_d    = '0;
      row_off_d = '0;
      blk_row_d = '0;
      col_off_d = '0;
    end else if (step_i) begin
      widx_d = widx_q + 4'(1);
      // Second half of a pixel row consumed: move down one image row.
      if (widx_q[0]) row_off_d = row_off_q + stride_c;
    end else if (adv_i) begin
      widx_d    = '0;
      row_off_d = '0;
      if (!last_x_c) begin
        blk_x_d   = blk_x_q + BW'(1);
        col_off_d = col_off_q + AW'(BLK_ROW_BYTES);
      end else begin
        blk_x_d   = '0;
        col_off_d = '0;
        if (!last_y_c) begin
          blk_y_d   = blk_y_q + BW'(1);
          blk_row_d = blk_row_q + stride_c * AW'(BLK_WORDS / 2);
        end
      end
    end
    m_adr_d = base_d + blk_row_d + row_off_d + col_off_d + AW'({widx_d[0], 2'b00});
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      base_q    <= '0;
      wblk_q    <= '0;
      hblk_q    <= '0;
      blk_x_q   <= '0;
      blk_y_q   <= '0;
      widx_q    <= '0;
      row_off_q <= '0;
      blk_row_q <= '0;
      col_off_q <= '0;
      m_adr_q   <= '0;
    end else begin
      base_q    <= base_d;
      wblk_q    <= wblk_d;
      hblk_q    <= hblk_d;
      blk_x_q   <= blk_x_d;
      blk_y_q   <= blk_y_d;
      widx_q    <= widx_d;
      row_off_q <= row_off_d;
      blk_row_q <= blk_row_d;
      col_off_q <= col_off_d;
      m_adr_q   <= m_adr_d;
    end
  end

  assign m_adr_o = m_adr_q;
  assign widx_o  = widx_q;
  assign blk_x_o = blk_x_q;
  assign blk_y_o = blk_y_q;

endmodule

// File: rtl/jpeg_block_sched.sv
// Raster-order 8x8 block scheduler: fetch 16 words, kick the DCT, hand the block to software.
module jpeg_block_sched
  import jpeg_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned BW = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [AW-1:0]       cfg_base_i,
  input  logic [BW-1:0]       cfg_wblk_i,
  input  logic [BW-1:0]       cfg_hblk_i,
  input  logic                start_i,
  input  logic                next_i,
  input  logic                abort_i,
  jpeg_block_sched_if.master  bus,
  output logic                start_dct_o,
  input  logic                dct_busy_i,
  output logic                busy_o,
  output logic                block_ready_o,
  output logic                done_o,
  output logic [BW-1:0]       blk_x_o,
  output logic [BW-1:0]       blk_y_o
);

  localparam logic [2:0] ST_IDLE    = SCHED_IDLE;
  localparam logic [2:0] ST_FETCH   = SCHED_FETCH;
  localparam logic [2:0] ST_KICK    = SCHED_KICK;
  localparam logic [2:0] ST_WAIT_HI = SCHED_WAIT_HI;
  localparam logic [2:0] ST_WAIT_LO = SCHED_WAIT_LO;
  localparam logic [2:0] ST_READY   = SCHED_READY;
  localparam logic [2:0] ST_ADVANCE = SCHED_ADVANCE;

  logic [2:0]  state_q, state_d;
  logic        m_req_q, m_req_d, bram_we_q, bram_we_d, start_dct_q, start_dct_d;
  logic        busy_q, busy_d, block_ready_q, block_ready_d, done_q, done_d;
  logic [8:0]  bram_adr_q, bram_adr_d;
  logic [31:0] bram_dat_q, bram_dat_d;
  logic        init_c, step_c, adv_c, last_word_c, last_block_c;
  logic [3:0]  widx;

  jpeg_blk_addr_gen #(.AW(AW), .BW(BW)) u_addr_gen (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .init_i       (init_c),
    .step_i       (step_c),
    .adv_i        (adv_c),
    .cfg_base_i   (cfg_base_i),
    .cfg_wblk_i   (cfg_wblk_i),
    .cfg_hblk_i   (cfg_hblk_i),
    .m_adr_o      (bus.m_adr_o),
    .widx_o       (widx),
    .blk_x_o      (blk_x_o),
    .blk_y_o      (blk_y_o),
    .last_word_c  (last_word_c),
    .last_block_c (last_block_c)
  );

  // Next state, counter strobes and registered output values; abort overrides everything.
  always_comb begin
    state_d    = state_q;
    done_d     = done_q;
    bram_we_d  = 1'b0;
    bram_adr_d = bram_adr_q;
    bram_dat_d = bram_dat_q;
    init_c     = 1'b0;
    step_c     = 1'b0;
    adv_c      = 1'b0;
    if (abort_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start_i) begin
          init_c = 1'b1;
          if (cfg_wblk_i == '0 || cfg_hblk_i == '0) begin
            done_d = 1'b1;
          end else begin
            done_d  = 1'b0;
            state_d = ST_FETCH;
          end
        end
        ST_FETCH: if (bus.m_ack_i) begin
          step_c     = 1'b1;
          bram_we_d  = 1'b1;
          bram_adr_d = 9'(widx);
          bram_dat_d = level_shift(bus.m_dat_i);
          if (last_word_c) state_d = ST_KICK;
        end
        ST_KICK:    state_d = ST_WAIT_HI;
        ST_WAIT_HI: if (dct_busy_i) state_d = ST_WAIT_LO;
        ST_WAIT_LO: if (!dct_busy_i) state_d = ST_READY;
        ST_READY:   if (next_i) state_d = ST_ADVANCE;
        ST_ADVANCE: begin
          adv_c = 1'b1;
          if (last_block_c) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_FETCH;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    m_req_d       = (state_d == ST_FETCH);
    start_dct_d   = (state_d == ST_KICK);
    busy_d        = (state_d != ST_IDLE);
    block_ready_d = (state_d == ST_READY);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q       <= ST_IDLE;
      m_req_q       <= 1'b0;
      bram_we_q     <= 1'b0;
      bram_adr_q    <= '0;
      bram_dat_q    <= '0;
      start_dct_q   <= 1'b0;
      busy_q        <= 1'b0;
      block_ready_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      m_req_q       <= m_req_d;
      bram_we_q     <= bram_we_d;
      bram_adr_q    <= bram_adr_d;
      bram_dat_q    <= bram_dat_d;
      start_dct_q   <= start_dct_d;
      busy_q        <= busy_d;
      block_ready_q <= block_ready_d;
      done_q        <= done_d;
    end
  end

  assign bus.m_req_o    = m_req_q;
  assign bus.bram_we_o  = bram_we_q;
  assign bus.bram_adr_o = bram_adr_q;
  assign bus.bram_dat_o = bram_dat_q;
  assign start_dct_o    = start_dct_q;
  assign busy_o         = busy_q;
  assign block_ready_o  = block_ready_q;
  assign done_o         = done_q;

endmodule

// File: tb/tb_jpeg_block_sched.sv
// Directed testbench for jpeg_block_sched with a simple wait-state bus slave and DCT stub.
module tb_jpeg_block_sched;
  localparam int unsigned AW = 32;
  localparam int unsigned BW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] cfg_base;
  logic [BW-1:0] cfg_wblk, cfg_hblk;
  logic          start, next, abort, dct_busy;
  logic          start_dct, busy, block_ready, done;
  logic [BW-1:0] blk_x, blk_y;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  always #5 clk = ~clk;

  jpeg_block_sched_if #(.AW(AW)) bus_if ();

  jpeg_block_sched #(.AW(AW), .BW(BW)) dut (
    .clk_i         (clk),
    .rst_i         (rst_n),
    .cfg_base_i    (cfg_base),
    .cfg_wblk_i    (cfg_wblk),
    .cfg_hblk_i    (cfg_hblk),
    .start_i       (start),
    .next_i        (next),
    .abort_i       (abort),
    .bus           (bus_if.master),
    .start_dct_o   (start_dct),
    .dct_busy_i    (dct_busy),
    .busy_o        (busy),
    .block_ready_o (block_ready),
    .done_o        (done),
    .blk_x_o       (blk_x),
    .blk_y_o       (blk_y)
  );

  // Bus slave: acks after wait_states idle cycles, logs acked addresses, checks address hold.
  bit          slave_en = 1'b1;
  int          wait_states = 0;
  int          dat_mode = 0;
  int          ack_cnt, adr_viol, wcnt;
  bit          pend;
  logic [31:0] held;
  logic [31:0] ack_log [0:127];

  function automatic logic [31:0] dat_gen(input int mode, input logic [31:0] a);
    if (mode == 0) return 32'h8080_8080;
    return {a[7:0], ~a[7:0], 8'h3C, a[9:2]};
  endfunction

  function automatic logic [31:0] exp_adr(input logic [31:0] base, input int w,
                                          input int bx, input int by, input int i);
    return base + 32'((by * 8 + i / 2) * w * 8 + bx * 8 + (i % 2) * 4);
  endfunction

  initial begin
    bus_if.m_ack_i = 1'b0;
    bus_if.m_dat_i = '0;
    forever begin
      @(negedge clk);
      if (slave_en) begin
        if (bus_if.m_req_o) begin
          if (pend && bus_if.m_adr_o !== held) adr_viol++;
          if (wcnt >= wait_states) begin
            bus_if.m_ack_i = 1'b1;
            bus_if.m_dat_i = dat_gen(dat_mode, bus_if.m_adr_o);
            if (ack_cnt < 128) ack_log[ack_cnt] = bus_if.m_adr_o;
            ack_cnt++;
            wcnt = 0;
            pend = 1'b0;
          end else begin
            bus_if.m_ack_i = 1'b0;
            wcnt++;
            pend = 1'b1;
            held = bus_if.m_adr_o;
          end
        end else begin
          bus_if.m_ack_i = 1'b0;
          wcnt = 0;
          pend = 1'b0;
        end
      end
    end
  end

  // RAM and pulse monitor.
  int          we_cnt, dct_cnt, req_cnt, bad_badr;
  logic [31:0] mem [0:15];
  always @(negedge clk) begin
    if (bus_if.bram_we_o) begin
      mem[bus_if.bram_adr_o[3:0]] = bus_if.bram_dat_o;
      we_cnt++;
      if (bus_if.bram_adr_o[8:4] != 5'd0) bad_badr++;
    end
    if (start_dct) dct_cnt++;
    if (bus_if.m_req_o) req_cnt++;
  end

  task automatic reset_counters();
    ack_cnt = 0; adr_viol = 0; we_cnt = 0; dct_cnt = 0; req_cnt = 0; bad_badr = 0;
    for (int i = 0; i < 16; i++) mem[i] = 32'hDEAD_BEEF;
  endtask

  task automatic pulse_start(input logic [31:0] b, input int w, input int h);
    cfg_base = b;
    cfg_wblk = BW'(w);
    cfg_hblk = BW'(h);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_next();
    next = 1'b1;
    @(negedge clk);
    next = 1'b0;
  endtask

  // sel: 0 start_dct, 1 block_ready, 2 m_req
  task automatic wait_sig(input int sel, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      case (sel)
        0: ok = start_dct;
        1: ok = block_ready;
        default: ok = bus_if.m_req_o;
      endcase
      if (ok) break;
    end
  endtask

  function automatic logic [94:0] out_vec();
    return {bus_if.m_req_o, bus_if.m_adr_o, bus_if.bram_we_o, bus_if.bram_adr_o,
            bus_if.bram_dat_o, start_dct, busy, block_ready, done, blk_x, blk_y};
  endfunction

  task automatic test_reset();
    logic [94:0] v;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    v = out_vec();
    chk_cnt++; if (v !== '0) $display("FAIL reset_initial: got %h want 0", v); else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
    reset_counters();
    wait_states = 3; dat_mode = 0;
    pulse_start(32'h1000, 1, 1);
    repeat (4) @(negedge clk);
    chk_cnt++;
    if ({busy, bus_if.m_req_o} !== 2'b11) $display("FAIL pre_reset_fetch: got %b want 11", {busy, bus_if.m_req_o});
    else pass_cnt++;
    rst_n = 1'b0;
    @(negedge clk);
    v = out_vec();
    chk_cnt++; if (v !== '0) $display("FAIL reset_mid_fetch_c1: got %h want 0", v); else pass_cnt++;
    @(negedge clk);
    v = out_vec();
    chk_cnt++; if (v !== '0) $display("FAIL reset_mid_fetch_c2: got %h want 0", v); else pass_cnt++;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if ({busy, bus_if.m_req_o} !== 2'b00) $display("FAIL post_reset_idle: got %b want 00", {busy, bus_if.m_req_o});
    else pass_cnt++;
  endtask

  task automatic test_single_block();
    bit ok;
    reset_counters();
    wait_states = 0; dat_mode = 0;
    pulse_start(32'h1000, 1, 1);
    wait_sig(0, 200, ok);
    chk_cnt++; if (ok !== 1'b1) $display("FAIL single_kick: got %b want 1", ok); else pass_cnt++;
    chk_cnt++; if (bus_if.m_req_o !== 1'b0) $display("FAIL single_req_low_at_kick: got %b want 0", bus_if.m_req_o); else pass_cnt++;
    dct_busy = 1'b1;
    repeat (40) @(negedge clk);
    dct_busy = 1'b0;
    wait_sig(1, 20, ok);
    chk_cnt++; if (ok !== 1'b1) $display("FAIL single_ready: got %b want 1", ok); else pass_cnt++;
    chk_cnt++; if (done !== 1'b0) $display("FAIL single_done_early: got %b want 0", done); else pass_cnt++;
    pulse_next();
    repeat (2) @(negedge clk);
    chk_cnt++;
    if ({done, busy, block_ready} !== 3'b100) $display("FAIL single_done: got %b want 100", {done, busy, block_ready});
    else pass_cnt++;
    chk_cnt++; if (ack_cnt !== 16) $display("FAIL single_acks: got %0d want 16", ack_cnt); else pass_cnt++;
    chk_cnt++; if (we_cnt !== 16) $display("FAIL single_writes: got %0d want 16", we_cnt); else pass_cnt++;
    chk_cnt++; if (dct_cnt !== 1) $display("FAIL single_dct_pulses: got %0d want 1", dct_cnt); else pass_cnt++;
    chk_cnt++; if (bad_badr !== 0) $display("FAIL single_bram_adr_hi: got %0d want 0", bad_badr); else pass_cnt++;
    for (int i = 0; i < 16; i++) begin
      chk_cnt++;
      if (ack_log[i] !== 32'h1000 + 32'(i * 4)) $display("FAIL single_adr%0d: got %h want %h", i, ack_log[i], 32'h1000 + 32'(i * 4));
      else pass_cnt++;
      chk_cnt++;
      if (mem[i] !== 32'h0) $display("FAIL single_ram%0d: got %h want 0", i, mem[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_raster();
    bit          ok;
    int          errs;
    logic [31:0] first_adr [0:3];
    logic [31:0] ea;
    first_adr[0] = 32'h00; first_adr[1] = 32'h08; first_adr[2] = 32'h80; first_adr[3] = 32'h88;
    reset_counters();
    wait_states = 0; dat_mode = 1;
    pulse_start(32'h0, 2, 2);
    for (int b = 0; b < 4; b++) begin
      wait_sig(0, 200, ok);
      chk_cnt++; if (ok !== 1'b1) $display("FAIL raster_kick%0d: got %b want 1", b, ok); else pass_cnt++;
      chk_cnt++;
      if ({blk_x, blk_y} !== {BW'(b % 2), BW'(b / 2)})
        $display("FAIL raster_pos%0d: got (%0d,%0d) want (%0d,%0d)", b, blk_x, blk_y, b % 2, b / 2);
      else pass_cnt++;
      dct_busy = 1'b1;
      repeat (5) @(negedge clk);
      dct_busy = 1'b0;
      wait_sig(1, 20, ok);
      chk_cnt++; if (ok !== 1'b1) $display("FAIL raster_ready%0d: got %b want 1", b, ok); else pass_cnt++;
      chk_cnt++;
      if (ack_log[b * 16] !== first_adr[b]) $display("FAIL raster_first_adr%0d: got %h want %h", b, ack_log[b * 16], first_adr[b]);
      else pass_cnt++;
      errs = 0;
      for (int i = 0; i < 16; i++) begin
        ea = exp_adr(32'h0, 2, b % 2, b / 2, i);
        if (ack_log[b * 16 + i] !== ea) errs++;
        if (mem[i] !== (dat_gen(1, ea) ^ 32'h8080_8080)) errs++;
      end
      chk_cnt++; if (errs !== 0) $display("FAIL raster_words%0d: got %0d bad want 0", b, errs); else pass_cnt++;
      chk_cnt++; if (done !== 1'b0) $display("FAIL raster_done_early%0d: got %b want 0", b, done); else pass_cnt++;
      pulse_next();
    end
    repeat (2) @(negedge clk);
    chk_cnt++; if ({done, busy} !== 2'b10) $display("FAIL raster_done: got %b want 10", {done, busy}); else pass_cnt++;
    chk_cnt++;
    if ({ack_cnt, we_cnt, dct_cnt} !== {32'd64, 32'd64, 32'd4})
      $display("FAIL raster_counts: got %0d/%0d/%0d want 64/64/4", ack_cnt, we_cnt, dct_cnt);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    bit ok;
    int errs;
    reset_counters();
    wait_states = 3; dat_mode = 1;
    pulse_start(32'h2000, 1, 1);
    wait_sig(0, 300, ok);
    chk_cnt++; if (ok !== 1'b1) $display("FAIL bp_kick: got %b want 1", ok); else pass_cnt++;
    chk_cnt++; if (bus_if.m_req_o !== 1'b0) $display("FAIL bp_req_low: got %b want 0", bus_if.m_req_o); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (adr_viol !== 0) $display("FAIL bp_adr_hold: got %0d changes want 0", adr_viol); else pass_cnt++;
    chk_cnt++; if (we_cnt !== 16) $display("FAIL bp_writes: got %0d want 16", we_cnt); else pass_cnt++;
    chk_cnt++; if (ack_cnt !== 16) $display("FAIL bp_acks: got %0d want 16", ack_cnt); else pass_cnt++;
    errs = 0;
    for (int i = 0; i < 16; i++) begin
      if (ack_log[i] !== 32'h2000 + 32'(i * 4)) errs++;
      if (mem[i] !== (dat_gen(1, 32'h2000 + 32'(i * 4)) ^ 32'h8080_8080)) errs++;
    end
    chk_cnt++; if (errs !== 0) $display("FAIL bp_words: got %0d bad want 0", errs); else pass_cnt++;
    dct_busy = 1'b1;
    repeat (3) @(negedge clk);
    dct_busy = 1'b0;
    wait_sig(1, 20, ok);
    pulse_next();
    repeat (2) @(negedge clk);
    chk_cnt++; if (done !== 1'b1) $display("FAIL bp_done: got %b want 1", done); else pass_cnt++;
  endtask

  task automatic test_zero_size();
    reset_counters();
    pulse_start(32'h500, 0, 3);
    chk_cnt++; if ({done, busy} !== 2'b10) $display("FAIL zero_w_done: got %b want 10", {done, busy}); else pass_cnt++;
    pulse_start(32'h0, 2, 0);
    chk_cnt++; if ({done, busy} !== 2'b10) $display("FAIL zero_h_done: got %b want 10", {done, busy}); else pass_cnt++;
    repeat (10) @(negedge clk);
    chk_cnt++;
    if ({req_cnt, dct_cnt, ack_cnt} !== 96'd0) $display("FAIL zero_no_activity: got %0d/%0d/%0d want 0/0/0", req_cnt, dct_cnt, ack_cnt);
    else pass_cnt++;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk_cnt++; if (done !== 1'b1) $display("FAIL abort_keeps_done: got %b want 1", done); else pass_cnt++;
  endtask

  task automatic test_abort_and_strobes();
    bit ok;
    // Abort while waiting for the DCT to finish.
    reset_counters();
    wait_states = 0; dat_mode = 0;
    pulse_start(32'h1000, 1, 1);
    wait_sig(0, 200, ok);
    chk_cnt++; if ({ok, done} !== 2'b10) $display("FAIL abort_setup: got %b want 10", {ok, done}); else pass_cnt++;
    dct_busy = 1'b1;
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk_cnt++;
    if ({busy, block_ready, start_dct, bus_if.m_req_o} !== 4'b0000)
      $display("FAIL abort_wait_lo: got %b want 0000", {busy, block_ready, start_dct, bus_if.m_req_o});
    else pass_cnt++;
    dct_busy = 1'b0;
    repeat (5) @(negedge clk);
    chk_cnt++; if ({busy, block_ready} !== 2'b00) $display("FAIL abort_stays_idle: got %b want 00", {busy, block_ready}); else pass_cnt++;
    chk_cnt++; if (we_cnt !== 16) $display("FAIL abort_writes: got %0d want 16", we_cnt); else pass_cnt++;

    // Ack coincident with abort in FETCH is dropped.
    slave_en = 1'b0;
    reset_counters();
    pulse_start(32'h3000, 1, 1);
    chk_cnt++; if (bus_if.m_req_o !== 1'b1) $display("FAIL abort_ack_req: got %b want 1", bus_if.m_req_o); else pass_cnt++;
    bus_if.m_ack_i = 1'b1;
    bus_if.m_dat_i = 32'h1234_5678;
    abort = 1'b1;
    @(negedge clk);
    bus_if.m_ack_i = 1'b0;
    abort = 1'b0;
    chk_cnt++;
    if ({bus_if.bram_we_o, busy, bus_if.m_req_o} !== 3'b000)
      $display("FAIL abort_ack_drop: got %b want 000", {bus_if.bram_we_o, busy, bus_if.m_req_o});
    else pass_cnt++;
    repeat (2) @(negedge clk);
    chk_cnt++; if (we_cnt !== 0) $display("FAIL abort_ack_writes: got %0d want 0", we_cnt); else pass_cnt++;
    slave_en = 1'b1;

    // next_i outside READY and start_i while busy are ignored.
    reset_counters();
    pulse_start(32'h1000, 1, 1);
    pulse_next();
    wait_sig(0, 200, ok);
    dct_busy = 1'b1;
    pulse_next();
    repeat (3) @(negedge clk);
    dct_busy = 1'b0;
    wait_sig(1, 20, ok);
    chk_cnt++; if (ok !== 1'b1) $display("FAIL ignored_next_ready: got %b want 1", ok); else pass_cnt++;
    pulse_start(32'h0, 0, 0);
    repeat (3) @(negedge clk);
    chk_cnt++;
    if ({busy, block_ready, done} !== 3'b110) $display("FAIL strobes_ignored: got %b want 110", {busy, block_ready, done});
    else pass_cnt++;
    pulse_next();
    repeat (2) @(negedge clk);
    chk_cnt++; if ({done, busy} !== 2'b10) $display("FAIL done_after_ignored: got %b want 10", {done, busy}); else pass_cnt++;
    chk_cnt++;
    if ({we_cnt, dct_cnt} !== {32'd16, 32'd1}) $display("FAIL ignored_counts: got %0d/%0d want 16/1", we_cnt, dct_cnt);
    else pass_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; cfg_base = '0; cfg_wblk = '0; cfg_hblk = '0;
    start = 1'b0; next = 1'b0; abort = 1'b0; dct_busy = 1'b0;
    reset_counters();
    @(negedge clk);
    test_reset();
    test_single_block();
    test_raster();
    test_backpressure();
    test_zero_size();
    test_abort_and_strobes();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
